// File: rtl/pl_gpio_capture_ctrl.sv
// PS-GPIO driven capture sequencer: fires one capture pulse, then waits for every
// enabled channel's done level to clear and re-assert, with timeout and abort.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no capture running, waiting for a CAP edge
// FIRE     | single cycle in which capture_o is high
// WAIT_CLR | waiting for enabled done levels from the last capture to drop
// WAIT_SET | waiting for all enabled done levels to assert
// DONE     | capture complete, counter bumped, ready for the next CAP edge
// TIMEOUT  | wait budget exhausted, timeout flag set, ready for a new CAP edge
module pl_gpio_capture_ctrl #(
    parameter int NUM_CH         = 8,
    parameter int GPIO_W         = 16,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              ps_clk,
    input  logic              ps_rst_n,
    input  logic [GPIO_W-1:0] gpio_from_ps,
    input  logic [GPIO_W-1:0] gpio_direction,
    output logic [GPIO_W-1:0] gpio_to_ps,
    output logic              capture_o,
    input  logic [NUM_CH-1:0] done_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_CLR,
        WAIT_SET,
        DONE,
        TIMEOUT
    } state_t;

    state_t state_q, state_nxt;

    logic [GPIO_W-1:0] cmd_qual;
    logic              cap_c0, cap_c1, cap_edge_q;
    logic              abort_q;
    logic [NUM_CH-1:0] mask_in_q;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] done_s;
    logic [NUM_CH-1:0] masked_done;

    logic [NUM_CH-1:0] mask_q, mask_nxt;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_nxt;
    logic              tmo_flag_q, tmo_flag_nxt;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_nxt;
    logic              busy;
    logic [GPIO_W-1:0] status_nxt;

    // A bit is a command only while the PS is actually driving it.
    assign cmd_qual    = gpio_from_ps & ~gpio_direction;
    assign done_s      = sync_q[SYNC_STAGES-1];
    assign masked_done = done_s & mask_q;

    logic unused_cmd;
    assign unused_cmd = ^cmd_qual[GPIO_W-1:NUM_CH+2];

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            cap_c0     <= 1'b0;
            cap_c1     <= 1'b0;
            cap_edge_q <= 1'b0;
            abort_q    <= 1'b0;
            mask_in_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            cap_c0     <= cmd_qual[0];
            cap_c1     <= cap_c0;
            cap_edge_q <= cap_c0 & ~cap_c1;
            abort_q    <= cmd_qual[1];
            mask_in_q  <= cmd_qual[2 +: NUM_CH];
            sync_q[0]  <= done_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        mask_nxt     = mask_q;
        tmo_cnt_nxt  = tmo_cnt_q;
        tmo_flag_nxt = tmo_flag_q;
        cap_cnt_nxt  = cap_cnt_q;

        if (abort_q) begin
            state_nxt    = IDLE;
            tmo_flag_nxt = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE, TIMEOUT: begin
                    if (cap_edge_q) begin
                        state_nxt    = FIRE;
                        mask_nxt     = mask_in_q;
                        tmo_flag_nxt = 1'b0;
                        tmo_cnt_nxt  = '0;
                    end
                end
                FIRE: state_nxt = WAIT_CLR;
                WAIT_CLR, WAIT_SET: begin
                    tmo_cnt_nxt = tmo_cnt_q + 1'b1;
                    // Timeout wins over a completion seen in the same cycle.
                    if (tmo_cnt_q == TMO_LAST) begin
                        state_nxt    = TIMEOUT;
                        tmo_flag_nxt = 1'b1;
                    end else if (state_q == WAIT_CLR) begin
                        if (masked_done == '0) begin
                            state_nxt = WAIT_SET;
                        end
                    end else if (masked_done == mask_q) begin
                        state_nxt   = DONE;
                        cap_cnt_nxt = cap_cnt_q + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q == FIRE) || (state_q == WAIT_CLR) || (state_q == WAIT_SET);
        status_nxt = '0;
        status_nxt[NUM_CH-1:0]      = done_s;
        status_nxt[NUM_CH]          = busy;
        status_nxt[NUM_CH+1]        = tmo_flag_q;
        status_nxt[NUM_CH+2 +: CNT_W] = cap_cnt_q;
    end

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
            cap_cnt_q  <= '0;
            capture_o  <= 1'b0;
            gpio_to_ps <= '0;
        end else begin
            state_q    <= state_nxt;
            mask_q     <= mask_nxt;
            tmo_cnt_q  <= tmo_cnt_nxt;
            tmo_flag_q <= tmo_flag_nxt;
            cap_cnt_q  <= cap_cnt_nxt;
            capture_o  <= (state_nxt == FIRE);
            gpio_to_ps <= status_nxt;
        end
    end

endmodule
